five_stage_pipeline_mips_32: RTL and testbench

FIVE_STAGE_PIPELINE_MIPS_32 -- requirements
Module: five_stage_pipeline_mips_32

---
 rtl/five_stage_pipeline_mips_32.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_five_stage_pipeline_mips_32.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/five_stage_pipeline_mips_32.sv
// five_stage_pipeline_mips_32 -- classic 5-stage (IF/ID/EX/MEM/WB) MIPS-32 subset.
//   Supports R-type AND/OR/ADD/SUB/SLT/NOR, LW, SW, BEQ (resolved in EX) and J
//   (resolved in ID). There are no delay slots. EX operands are forwarded from
//   EX/MEM and MEM/WB, and a load-use hazard costs one stall cycle.
//   Ports:
//     clk - single clock; all state updates on the rising edge
//     rst - asynchronous, active-low reset
//   Memories are reached hierarchically through inst_mem.memory,
//   data_mem.memory and reg_file.memory. The program counter is a word index.

// Word-addressed memory with one write port and a combinational read port.
// The read is combinational so that the IF and MEM stages finish in one cycle.
module mips_mem #(
  parameter int WORDS = 64,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);
  logic [31:0] memory [WORDS];

  // Contents are never reset: they survive rst.
  always @(posedge clk) begin
    if (wr_en) memory[wr_addr] <= wr_data;
  end

  assign rd_data = memory[rd_addr];
endmodule

// 32 x 32 register file. Reset loads register i with the value i. A read of the
// register being written in the same cycle returns the new value.
module mips_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);
  logic [31:0] memory [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) memory[i] <= 32'(i);
    end else if (wr_en) begin
      memory[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : memory[rd_addr_a];
  assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : memory[rd_addr_b];
endmodule

module five_stage_pipeline_mips_32 #(
  parameter int DMEM_WORDS = 64,
  parameter int IMEM_WORDS = 64
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR  = 3'd3, ALU_NOR = 3'd4, ALU_SLT = 3'd5;

  // ---------------- IF ----------------
  logic [31:0]    program_counter;
  logic [IAW-1:0] imem_rd_addr;
  logic [31:0]    if_instr;

  assign imem_rd_addr = IAW'(program_counter % 32'(IMEM_WORDS));

  mips_mem #(.WORDS(IMEM_WORDS)) inst_mem (
    .clk(clk), .wr_en(1'b0), .wr_addr('0), .wr_data('0),
    .rd_addr(imem_rd_addr), .rd_data(if_instr)
  );

  // IF/ID. The all-zero instruction decodes to a NOP (R-type, funct 0), so it is the bubble.
  logic [31:0] if_id_instr_reg, if_id_pc_plus1_reg;

  // ---------------- ID ----------------
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, id_rs_val, id_rt_val, jump_target;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_use_imm;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_dest;

  assign id_op       = if_id_instr_reg[31:26];
  assign id_rs       = if_id_instr_reg[25:21];
  assign id_rt       = if_id_instr_reg[20:16];
  assign id_rd       = if_id_instr_reg[15:11];
  assign id_funct    = if_id_instr_reg[5:0];
  assign id_imm      = {{16{if_id_instr_reg[15]}}, if_id_instr_reg[15:0]};
  assign jump_target = {if_id_pc_plus1_reg[31:26], if_id_instr_reg[25:0]};

  always_comb begin
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    id_branch    = 1'b0;
    id_jump      = 1'b0;
    id_use_imm   = 1'b0;
    id_alu_op    = ALU_ADD;
    id_dest      = id_rd;
    case (id_op)
      6'b000000: begin
        id_reg_write = 1'b1;
        case (id_funct)
          6'b100100: id_alu_op = ALU_AND;
          6'b100101: id_alu_op = ALU_OR;
          6'b100000: id_alu_op = ALU_ADD;
          6'b100010: id_alu_op = ALU_SUB;
          6'b101010: id_alu_op = ALU_SLT;
          6'b100111: id_alu_op = ALU_NOR;
          default:   id_reg_write = 1'b0;  // unknown funct executes as a NOP
        endcase
      end
      6'b100011: begin
        id_reg_write = 1'b1;
        id_mem_read  = 1'b1;
        id_use_imm   = 1'b1;
        id_dest      = id_rt;
      end
      6'b101011: begin
        id_mem_write = 1'b1;
        id_use_imm   = 1'b1;
      end
      6'b000100: id_branch = 1'b1;
      6'b000010: id_jump   = 1'b1;
      default: ;
    endcase
  end

  // ID/EX
  logic        id_ex_reg_write_reg, id_ex_mem_read_reg, id_ex_mem_write_reg;
  logic        id_ex_branch_reg, id_ex_use_imm_reg;
  logic [2:0]  id_ex_alu_op_reg;
  logic [4:0]  id_ex_dest_reg, id_ex_rs_reg, id_ex_rt_reg;
  logic [31:0] id_ex_rs_val_reg, id_ex_rt_val_reg, id_ex_imm_reg, id_ex_pc_plus1_reg;

  // EX/MEM and MEM/WB
  logic        ex_mem_reg_write_reg, ex_mem_mem_read_reg, ex_mem_mem_write_reg;
  logic [4:0]  ex_mem_dest_reg;
  logic [31:0] ex_mem_alu_result_reg, ex_mem_store_data_reg;
  logic        mem_wb_reg_write_reg;
  logic [4:0]  mem_wb_dest_reg;
  logic [31:0] mem_wb_data_reg;

  mips_reg_file reg_file (
    .clk(clk), .rst(rst),
    .rd_addr_a(id_rs), .rd_addr_b(id_rt),
    .rd_data_a(id_rs_val), .rd_data_b(id_rt_val),
    .wr_en(mem_wb_reg_write_reg), .wr_addr(mem_wb_dest_reg), .wr_data(mem_wb_data_reg)
  );

  // A load in EX cannot forward to the instruction in ID in time. This check is
  // conservative: it compares both fields even for instructions that ignore rt.
  logic load_use;
  assign load_use = id_ex_mem_read_reg && (id_ex_dest_reg == id_rs || id_ex_dest_reg == id_rt);

  // ---------------- EX ----------------
  logic [31:0] ex_op_a, ex_fwd_b, ex_op_b, ex_result, branch_target;
  logic        branch_taken;

  always_comb begin
    ex_op_a = id_ex_rs_val_reg;
    if (ex_mem_reg_write_reg && ex_mem_dest_reg == id_ex_rs_reg)
      ex_op_a = ex_mem_alu_result_reg;
    else if (mem_wb_reg_write_reg && mem_wb_dest_reg == id_ex_rs_reg)
      ex_op_a = mem_wb_data_reg;

    ex_fwd_b = id_ex_rt_val_reg;
    if (ex_mem_reg_write_reg && ex_mem_dest_reg == id_ex_rt_reg)
      ex_fwd_b = ex_mem_alu_result_reg;
    else if (mem_wb_reg_write_reg && mem_wb_dest_reg == id_ex_rt_reg)
      ex_fwd_b = mem_wb_data_reg;
  end

  assign ex_op_b = id_ex_use_imm_reg ? id_ex_imm_reg : ex_fwd_b;

  always_comb begin
    ex_result = ex_op_a + ex_op_b;
    case (id_ex_alu_op_reg)
      ALU_SUB: ex_result = ex_op_a - ex_op_b;
      ALU_AND: ex_result = ex_op_a & ex_op_b;
      ALU_OR:  ex_result = ex_op_a | ex_op_b;
      ALU_NOR: ex_result = ~(ex_op_a | ex_op_b);
      ALU_SLT: ex_result = {31'b0, $signed(ex_op_a) < $signed(ex_op_b)};
      default: ex_result = ex_op_a + ex_op_b;
    endcase
  end

  assign branch_taken  = id_ex_branch_reg && (ex_op_a == ex_fwd_b);
  assign branch_target = id_ex_pc_plus1_reg + id_ex_imm_reg;

  // ---------------- MEM ----------------
  logic [DAW-1:0] dmem_addr;
  logic [31:0]    dmem_rd_data;

  assign dmem_addr = DAW'(ex_mem_alu_result_reg % 32'(DMEM_WORDS));

  mips_mem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk(clk), .wr_en(ex_mem_mem_write_reg), .wr_addr(dmem_addr),
    .wr_data(ex_mem_store_data_reg), .rd_addr(dmem_addr), .rd_data(dmem_rd_data)
  );

  // ---------------- state ----------------
  // A taken branch overrides everything. A stall freezes a J that is still in
  // ID, so the jump takes effect only after the stall ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      program_counter    <= '0;
      if_id_instr_reg    <= '0;
      if_id_pc_plus1_reg <= '0;
    end else if (branch_taken) begin
      program_counter    <= branch_target;
      if_id_instr_reg    <= '0;
    end else if (load_use) begin
      program_counter    <= program_counter;
    end else if (id_jump) begin
      program_counter    <= jump_target;
      if_id_instr_reg    <= '0;
    end else begin
      program_counter    <= program_counter + 32'd1;
      if_id_instr_reg    <= if_instr;
      if_id_pc_plus1_reg <= program_counter + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || branch_taken || load_use) begin
      id_ex_reg_write_reg <= 1'b0;
      id_ex_mem_read_reg  <= 1'b0;
      id_ex_mem_write_reg <= 1'b0;
      id_ex_branch_reg    <= 1'b0;
      id_ex_use_imm_reg   <= 1'b0;
      id_ex_alu_op_reg    <= ALU_ADD;
      id_ex_dest_reg      <= '0;
      id_ex_rs_reg        <= '0;
      id_ex_rt_reg        <= '0;
      id_ex_rs_val_reg    <= '0;
      id_ex_rt_val_reg    <= '0;
      id_ex_imm_reg       <= '0;
      id_ex_pc_plus1_reg  <= '0;
    end else begin
      id_ex_reg_write_reg <= id_reg_write;
      id_ex_mem_read_reg  <= id_mem_read;
      id_ex_mem_write_reg <= id_mem_write;
      id_ex_branch_reg    <= id_branch;
      id_ex_use_imm_reg   <= id_use_imm;
      id_ex_alu_op_reg    <= id_alu_op;
      id_ex_dest_reg      <= id_dest;
      id_ex_rs_reg        <= id_rs;
      id_ex_rt_reg        <= id_rt;
      id_ex_rs_val_reg    <= id_rs_val;
      id_ex_rt_val_reg    <= id_rt_val;
      id_ex_imm_reg       <= id_imm;
      id_ex_pc_plus1_reg  <= if_id_pc_plus1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_mem_reg_write_reg  <= 1'b0;
      ex_mem_mem_read_reg   <= 1'b0;
      ex_mem_mem_write_reg  <= 1'b0;
      ex_mem_dest_reg       <= '0;
      ex_mem_alu_result_reg <= '0;
      ex_mem_store_data_reg <= '0;
      mem_wb_reg_write_reg  <= 1'b0;
      mem_wb_dest_reg       <= '0;
      mem_wb_data_reg       <= '0;
    end else begin
      ex_mem_reg_write_reg  <= id_ex_reg_write_reg;
      ex_mem_mem_read_reg   <= id_ex_mem_read_reg;
      ex_mem_mem_write_reg  <= id_ex_mem_write_reg;
      ex_mem_dest_reg       <= id_ex_dest_reg;
      ex_mem_alu_result_reg <= ex_result;
      ex_mem_store_data_reg <= ex_fwd_b;
      mem_wb_reg_write_reg  <= ex_mem_reg_write_reg;
      mem_wb_dest_reg       <= ex_mem_dest_reg;
      mem_wb_data_reg       <= ex_mem_mem_read_reg ? dmem_rd_data : ex_mem_alu_result_reg;
    end
  end
endmodule

// File: tb/tb_five_stage_pipeline_mips_32.sv
// Self-checking bench for five_stage_pipeline_mips_32. Each program pushes its
// expected register/memory commits (with commit edge) into a scoreboard. A
// monitor pops and compares those commits as the pipeline produces them.
module tb_five_stage_pipeline_mips_32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  five_stage_pipeline_mips_32 #(.DMEM_WORDS(64), .IMEM_WORDS(64)) dut (
    .clk(clk),
    .rst(rst)
  );

  typedef struct {
    int          kind;   // 0 = register write, 1 = memory write
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;    // rising edge (counted from reset release) of the commit
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_ADD = 6'b100000,
                         F_SUB = 6'b100010, F_SLT = 6'b101010, F_NOR = 6'b100111;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'b000010, target};
  endfunction

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data, input int c);
    sb_entry_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic sb_match(input int kind, input logic [31:0] addr, input logic [31:0] data);
    sb_entry_t e;
    string k;
    k = (kind == 0) ? "reg" : "mem";
    $display("txn %s addr=%0d data=0x%08h edge=%0d", k, addr, data, cyc + 1);
    check_eq({k, "_expected"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({k, "_kind"}, 32'(kind), 32'(e.kind));
      check_eq({k, "_addr"}, addr, e.addr);
      check_eq({k, "_data"}, data, e.data);
      check_eq({k, "_edge"}, 32'(cyc + 1), 32'(e.cyc));
    end
  endtask

  always @(posedge clk) begin
    if (!rst) cyc = 0;
    else cyc = cyc + 1;
  end

  // Commits happen on the next rising edge: observe them half a cycle earlier.
  always @(negedge clk) begin
    if (rst) begin
      if (dut.mem_wb_reg_write_reg)
        sb_match(0, 32'(dut.mem_wb_dest_reg), dut.mem_wb_data_reg);
      if (dut.ex_mem_mem_write_reg)
        sb_match(1, 32'(dut.dmem_addr), dut.ex_mem_store_data_reg);
    end
  end

  // Enter reset at a falling edge and restore memories to a known image.
  task automatic begin_test();
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      dut.data_mem.memory[i] = 32'(i);
      dut.inst_mem.memory[i] = 32'h0;
    end
  endtask

  task automatic run_test(input string name, input int n);
    repeat (2) @(negedge clk);
    check_eq({name, "_rst_pc"}, dut.program_counter, 32'd0);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    check_eq({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  logic [5:0]  v_funct [3] = '{F_ADD, F_SUB, F_SLT};
  logic [15:0] v_a     [3] = '{16'd5, 16'd5, 16'd4};
  logic [15:0] v_b     [3] = '{16'd3, 16'd3, 16'd5};
  logic [31:0] v_exp   [3] = '{32'd8, 32'd2, 32'd1};

  initial begin
    // Reset state: PC, register file image and empty pipeline.
    begin_test();
    repeat (2) @(negedge clk);
    check_eq("reset_pc", dut.program_counter, 32'd0);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("reset_r%0d", i), dut.reg_file.memory[i], 32'(i));
    check_eq("reset_mem_wb_we", 32'(dut.mem_wb_reg_write_reg), 32'd0);
    check_eq("reset_ex_mem_we", 32'(dut.ex_mem_mem_write_reg), 32'd0);

    // LW r0 <- mem[r31 + 0] commits four edges after fetch.
    dut.inst_mem.memory[0] = enc_i(OP_LW, 5'd0, 5'd31, 16'd0);
    push(0, 0, 31, 5);
    run_test("lw", 8);
    check_eq("lw_r0", dut.reg_file.memory[0], 32'd31);

    // SW mem[r0 + 0] <- r3 writes memory three edges after fetch.
    begin_test();
    dut.inst_mem.memory[0] = enc_i(OP_SW, 5'd3, 5'd0, 16'd0);
    push(1, 0, 3, 4);
    run_test("sw", 8);
    check_eq("sw_mem0", dut.data_mem.memory[0], 32'd3);

    // Load-use stall plus forwarding into an ALU op and a dependent store.
    for (int v = 0; v < 3; v++) begin
      begin_test();
      dut.inst_mem.memory[0] = enc_i(OP_LW, 5'd1, 5'd0, v_a[v]);
      dut.inst_mem.memory[1] = enc_i(OP_LW, 5'd2, 5'd0, v_b[v]);
      dut.inst_mem.memory[2] = enc_r(v_funct[v], 5'd3, 5'd1, 5'd2);
      dut.inst_mem.memory[3] = enc_i(OP_SW, 5'd3, 5'd0, 16'd14);
      push(0, 1, 32'(v_a[v]), 5);
      push(0, 2, 32'(v_b[v]), 6);
      push(0, 3, v_exp[v], 8);
      push(1, 14, v_exp[v], 8);
      run_test($sformatf("hazard%0d", v), 12);
      check_eq($sformatf("hazard%0d_mem14", v), dut.data_mem.memory[14], v_exp[v]);
    end

    // Logic ops, wrapping SUB, and signed SLT fed from EX/MEM.
    begin_test();
    dut.inst_mem.memory[0] = enc_i(OP_LW, 5'd1, 5'd0, 16'd22);
    dut.inst_mem.memory[1] = enc_i(OP_LW, 5'd2, 5'd0, 16'd12);
    dut.inst_mem.memory[2] = enc_r(F_AND, 5'd3, 5'd1, 5'd2);
    dut.inst_mem.memory[3] = enc_r(F_OR,  5'd4, 5'd1, 5'd2);
    dut.inst_mem.memory[4] = enc_r(F_NOR, 5'd5, 5'd1, 5'd2);
    dut.inst_mem.memory[5] = enc_r(F_SUB, 5'd6, 5'd2, 5'd1);
    dut.inst_mem.memory[6] = enc_r(F_SLT, 5'd7, 5'd6, 5'd0);
    push(0, 1, 22, 5);
    push(0, 2, 12, 6);
    push(0, 3, 32'd4, 8);
    push(0, 4, 32'd30, 9);
    push(0, 5, 32'hFFFF_FFE1, 10);
    push(0, 6, 32'hFFFF_FFF6, 11);
    push(0, 7, 32'd1, 12);
    run_test("alu", 16);
    check_eq("alu_r5", dut.reg_file.memory[5], 32'hFFFF_FFE1);

    // Taken BEQ squashes PC 1 and 2; unknown op/funct are NOPs.
    begin_test();
    dut.inst_mem.memory[0] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd2);
    dut.inst_mem.memory[1] = enc_r(F_ADD, 5'd8, 5'd1, 5'd2);
    dut.inst_mem.memory[2] = enc_i(OP_SW, 5'd1, 5'd0, 16'd20);
    dut.inst_mem.memory[3] = enc_r(F_ADD, 5'd9, 5'd1, 5'd2);
    dut.inst_mem.memory[4] = enc_i(6'b111111, 5'd12, 5'd1, 16'd5);
    dut.inst_mem.memory[5] = enc_r(6'b111111, 5'd13, 5'd1, 5'd2);
    push(0, 9, 3, 8);
    run_test("beq", 14);
    check_eq("beq_r8", dut.reg_file.memory[8], 32'd8);
    check_eq("beq_mem20", dut.data_mem.memory[20], 32'd20);
    check_eq("nop_r12", dut.reg_file.memory[12], 32'd12);
    check_eq("nop_r13", dut.reg_file.memory[13], 32'd13);

    // J flushes PC 1 and continues at PC 10.
    begin_test();
    dut.inst_mem.memory[0]  = enc_j(26'd10);
    dut.inst_mem.memory[1]  = enc_r(F_ADD, 5'd8, 5'd1, 5'd2);
    dut.inst_mem.memory[10] = enc_r(F_ADD, 5'd9, 5'd3, 5'd4);
    push(0, 9, 7, 7);
    run_test("jump", 12);
    check_eq("jump_r8", dut.reg_file.memory[8], 32'd8);

    // Reset asserted while an SW sits in EX: the store is discarded.
    begin_test();
    dut.inst_mem.memory[0] = enc_i(OP_SW, 5'd5, 5'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort_sw_in_ex", 32'(dut.id_ex_mem_write_reg), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("abort_pc_async", dut.program_counter, 32'd0);
    check_eq("abort_id_ex_bubble", 32'(dut.id_ex_mem_write_reg), 32'd0);
    dut.inst_mem.memory[0] = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("abort_mem0", dut.data_mem.memory[0], 32'd0);
    rst = 1'b1;
    check_eq("abort_pc_release", dut.program_counter, 32'd0);
    @(posedge clk);
    #1;
    check_eq("abort_pc_step", dut.program_counter, 32'd1);
    repeat (6) @(negedge clk);
    check_eq("abort_mem0_after", dut.data_mem.memory[0], 32'd0);
    check_eq("abort_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
